// File: rtl/branch_resolver_pkg.sv
// Shared opcodes, funct3 codes and FSM state encoding for the branch resolver.
package branch_resolver_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_NOP    = 7'b0010011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RESOLVE  = 3'd2,
        ST_LINK     = 3'd3,
        ST_REDIRECT = 3'd4
    } state_e;

    // True for the three control-transfer opcodes this block handles.
    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_resolver_cmp.sv
// Combinational branch condition evaluator: taken = f(fun3, a, b).
module branch_cmp
    import branch_resolver_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken
);

    // Reserved funct3 codes (010/011) fall through to not-taken.
    always_comb begin
        taken = 1'b0;
        case (fun3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves BRANCH/JAL/JALR: reads operands, computes the redirect target,
// writes the link register when needed, then pulses get_npc to fetch.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit LINK_ZERO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [2:0]      fun3,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] opc,
    output logic            rf_req,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic            rf_valid,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            wb_ack,
    output logic [XLEN-1:0] npc,
    output logic            get_npc,
    output logic            busy
);

    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] CLR_BIT0  = {{(XLEN-1){1'b1}}, 1'b0};

    state_e          state_q, state_d;
    logic [6:0]      op_q,    op_d;
    logic [4:0]      rd_q,    rd_d;
    logic [2:0]      fun3_q,  fun3_d;
    logic [4:0]      rs1_q,   rs1_d;
    logic [4:0]      rs2_q,   rs2_d;
    logic [XLEN-1:0] imm_q,   imm_d;
    logic [XLEN-1:0] opc_q,   opc_d;
    logic [XLEN-1:0] a_q,     a_d;
    logic [XLEN-1:0] b_q,     b_d;
    logic [XLEN-1:0] npc_q,   npc_d;

    logic            taken;
    logic            need_link;
    logic [XLEN-1:0] link_addr;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .fun3  (fun3_q),
        .a     (a_q),
        .b     (b_q),
        .taken (taken)
    );

    assign link_addr = opc_q + FOUR;
    // x0 links are dropped unless the debug override asks for them.
    assign need_link = (op_q != OP_BRANCH) && ((rd_q != 5'd0) || LINK_ZERO);

    // Next-state and datapath latch logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        fun3_d  = fun3_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        npc_d   = npc_q;
        case (state_q)
            ST_IDLE: begin
                if (is_ctrl(opcode)) begin
                    op_d    = opcode;
                    rd_d    = rd;
                    fun3_d  = fun3;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    imm_d   = imm;
                    opc_d   = opc;
                    state_d = (opcode == OP_JAL) ? ST_RESOLVE : ST_READ;
                end
            end
            ST_READ: begin
                if (rf_valid) begin
                    a_d     = rf_rd1;
                    b_d     = rf_rd2;
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                // All adds wrap modulo 2^XLEN; misaligned targets pass through.
                if (op_q == OP_BRANCH)
                    npc_d = taken ? (opc_q + imm_q) : link_addr;
                else if (op_q == OP_JAL)
                    npc_d = opc_q + imm_q;
                else
                    npc_d = (a_q + imm_q) & CLR_BIT0;
                state_d = need_link ? ST_LINK : ST_REDIRECT;
            end
            ST_LINK: begin
                if (wb_ack)
                    state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state; zero outside their state.
    always_comb begin
        rf_req  = 1'b0;
        rf_ra1  = 5'd0;
        rf_ra2  = 5'd0;
        wb_en   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = '0;
        get_npc = 1'b0;
        busy    = (state_q != ST_IDLE);
        npc     = npc_q;
        case (state_q)
            ST_READ: begin
                rf_req = 1'b1;
                rf_ra1 = rs1_q;
                rf_ra2 = (op_q == OP_JALR) ? 5'd0 : rs2_q;
            end
            ST_LINK: begin
                wb_en   = 1'b1;
                wb_rd   = rd_q;
                wb_data = link_addr;
            end
            ST_REDIRECT: begin
                get_npc = 1'b1;
            end
            default: ;
        endcase
    end

    // State and latch registers; synchronous reset clears everything incl. npc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            fun3_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            fun3_q  <= fun3_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            npc_q   <= npc_d;
        end
    end

endmodule
